// File: rtl/shift_rows_stream.sv
// Byte-serial AES ShiftRows / InvShiftRows engine.
// Ping-pong 16-byte banks; the read side applies the row permutation when addressing the bank.
module shift_rows_stream #(
  parameter bit INVERSE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       frame_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned NB = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

  logic [DW-1:0] mem [2][NB];
  logic [1:0]    full;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;
  logic          wr_bank;
  logic          rd_bank;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic          wr_fire;
  logic          rd_fire;
  logic          wr_commit;
  logic          rd_done;

  // Source index in the stored state for output byte k (k = r + 4c).
  function automatic logic [CW-1:0] perm(input logic [CW-1:0] k);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] col;
    r   = k[1:0];
    c   = k[3:2];
    col = INVERSE ? (c - r) : (c + r);
    return {col, r};
  endfunction

  assign s_ready   = !full[wr_bank];
  assign m_valid   = full[rd_bank];
  assign m_data    = mem[rd_bank][perm(rd_cnt)];
  assign m_last    = m_valid && (rd_cnt == LAST_IDX);

  assign wr_fire   = s_valid && s_ready;
  assign rd_fire   = m_valid && m_ready;
  assign wr_commit = wr_fire && (wr_cnt == LAST_IDX);
  assign rd_done   = rd_fire && (rd_cnt == LAST_IDX);

  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (wr_commit) full_set[wr_bank] = 1'b1;
    if (rd_done)   full_clr[rd_bank] = 1'b1;
  end

  // Byte storage; a bank is never written while it is being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(NB); i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (wr_fire) begin
      mem[wr_bank][wr_cnt] <= s_data;
    end
  end

  // Write side: fill counter, bank commit and framing checks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (wr_fire) begin
        if (wr_cnt == LAST_IDX) begin
          wr_bank   <= ~wr_bank;
          wr_cnt    <= '0;
          frame_err <= !s_last;
        end else if (s_last) begin
          // Early s_last: drop the partial state in place.
          wr_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end
    end
  end

  // Read side: drain counter and bank release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else if (rd_fire) begin
      if (rd_cnt == LAST_IDX) begin
        rd_bank <= ~rd_bank;
        rd_cnt  <= '0;
      end else begin
        rd_cnt <= rd_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      full <= (full | full_set) & ~full_clr;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: forward and inverse instances, queue scoreboard
// fed at stimulus time and drained by an output monitor.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       f_s_valid, f_s_ready, f_s_last, f_m_valid, f_m_ready, f_m_last, f_frame_err;
  logic [7:0] f_s_data, f_m_data;
  logic       i_s_valid, i_s_ready, i_s_last, i_m_valid, i_m_ready, i_m_last, i_frame_err;
  logic [7:0] i_s_data, i_m_data;

  shift_rows_stream #(.INVERSE(1'b0)) u_fwd (
    .clk(clk), .rst_n(rst_n),
    .s_valid(f_s_valid), .s_ready(f_s_ready), .s_data(f_s_data), .s_last(f_s_last),
    .m_valid(f_m_valid), .m_ready(f_m_ready), .m_data(f_m_data), .m_last(f_m_last),
    .frame_err(f_frame_err)
  );

  shift_rows_stream #(.INVERSE(1'b1)) u_inv (
    .clk(clk), .rst_n(rst_n),
    .s_valid(i_s_valid), .s_ready(i_s_ready), .s_data(i_s_data), .s_last(i_s_last),
    .m_valid(i_m_valid), .m_ready(i_m_ready), .m_data(i_m_data), .m_last(i_m_last),
    .frame_err(i_frame_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stalls = 0;
  int f_beats = 0;
  int beat_cyc [1024];
  logic [8:0] q_f [$];
  logic [8:0] q_i [$];
  logic [7:0] st [16];
  logic [7:0] ex [16];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a beat transfers at the next rising edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && f_m_valid && f_m_ready) begin
      if (q_f.size() == 0) chk("fwd_unexpected_beat", {7'd0, f_m_last, f_m_data}, 16'hffff);
      else begin
        e = q_f.pop_front();
        chk("fwd_out", {7'd0, f_m_last, f_m_data}, {7'd0, e});
      end
      if (f_beats < 1024) beat_cyc[f_beats] = cyc;
      f_beats++;
    end
    if (rst_n && i_m_valid && i_m_ready) begin
      if (q_i.size() == 0) chk("inv_unexpected_beat", {7'd0, i_m_last, i_m_data}, 16'hffff);
      else begin
        e = q_i.pop_front();
        chk("inv_out", {7'd0, i_m_last, i_m_data}, {7'd0, e});
      end
    end
  end

  // Independent ShiftRows model on the 4x4 state (row r, column c).
  task automatic model(input bit inv);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ex[r + 4 * c] = inv ? st[r + 4 * ((c - r + 4) % 4)] : st[r + 4 * ((c + r) % 4)];
  endtask

  task automatic push(input int sel);
    for (int k = 0; k < 16; k++) begin
      if (sel == 0) q_f.push_back({k == 15, ex[k]});
      else          q_i.push_back({k == 15, ex[k]});
    end
  endtask

  task automatic rand_state();
    for (int k = 0; k < 16; k++) st[k] = 8'($urandom);
  endtask

  // Offer one byte; returns 1 ns after the accepting edge with s_valid still high.
  task automatic send_byte(input int sel, input logic [7:0] d, input logic last);
    bit ok;
    logic rdy;
    ok = 1'b0;
    rdy = 1'b0;
    if (sel == 0) begin f_s_valid = 1'b1; f_s_data = d; f_s_last = last; end
    else          begin i_s_valid = 1'b1; i_s_data = d; i_s_last = last; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = (sel == 0) ? f_s_ready : i_s_ready;
      if (rdy) begin ok = 1'b1; break; end
      stalls++;
    end
    if (!ok) chk("s_ready_timeout", {15'd0, rdy}, 16'd1);
    else begin @(posedge clk); #1; end
  endtask

  task automatic send_state(input int sel, input int n, input int last_at);
    for (int k = 0; k < n; k++) send_byte(sel, st[k], k == last_at);
    if (sel == 0) f_s_valid = 1'b0; else i_s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int sel);
    for (int i = 0; i < 400; i++) begin
      if (((sel == 0) ? q_f.size() : q_i.size()) == 0) break;
      @(negedge clk);
    end
    chk("drain_left", 16'((sel == 0) ? q_f.size() : q_i.size()), 16'd0);
    @(posedge clk); #1;
    chk("idle_m_valid", {15'd0, (sel == 0) ? f_m_valid : i_m_valid}, 16'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0;
    logic [8:0] held;
    rst_n = 1'b0;
    f_s_valid = 1'b0; f_s_data = '0; f_s_last = 1'b0; f_m_ready = 1'b1;
    i_s_valid = 1'b0; i_s_data = '0; i_s_last = 1'b0; i_m_ready = 1'b1;
    #2;
    chk("rst_s_ready", {15'd0, f_s_ready}, 16'd1);
    chk("rst_m_valid", {15'd0, f_m_valid}, 16'd0);
    chk("rst_m_data", {8'd0, f_m_data}, 16'h00);
    chk("rst_m_last", {15'd0, f_m_last}, 16'd0);
    chk("rst_frame_err", {15'd0, f_frame_err}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer forward state with latency check.
    st = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
           8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    ex = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
           8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    push(0);
    for (int k = 0; k < 15; k++) send_byte(0, st[k], 1'b0);
    chk("kat_m_valid_before", {15'd0, f_m_valid}, 16'd0);
    send_byte(0, st[15], 1'b1);
    f_s_valid = 1'b0;
    chk("kat_latency_m_valid", {15'd0, f_m_valid}, 16'd1);
    chk("kat_frame_err", {15'd0, f_frame_err}, 16'd0);
    wait_drain(0);

    // Inverse instance recovers the original state.
    st = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
           8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    ex = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
           8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    push(1);
    send_state(1, 16, 15);
    wait_drain(1);
    rand_state(); model(1'b1); push(1);
    send_state(1, 16, 15);
    wait_drain(1);

    // Back-to-back: 8 random states at full rate.
    b0 = f_beats;
    stalls = 0;
    for (int s = 0; s < 8; s++) begin
      rand_state(); model(1'b0); push(0);
      send_state(0, 16, 15);
    end
    chk("b2b_stalls", 16'(stalls), 16'd0);
    wait_drain(0);
    chk("b2b_beats", 16'(f_beats - b0), 16'd128);
    chk("b2b_span", 16'(beat_cyc[b0 + 127] - beat_cyc[b0]), 16'd127);

    // Backpressure: both banks fill, then drain resumes the third state.
    f_m_ready = 1'b0;
    b0 = f_beats;
    for (int s = 0; s < 2; s++) begin
      rand_state(); model(1'b0); push(0);
      send_state(0, 16, 15);
    end
    chk("bp_s_ready_low", {15'd0, f_s_ready}, 16'd0);
    held = {f_m_last, f_m_data};
    repeat (5) @(posedge clk);
    #1;
    chk("bp_hold_data", {7'd0, f_m_last, f_m_data}, {7'd0, held});
    chk("bp_hold_valid", {15'd0, f_m_valid}, 16'd1);
    chk("bp_still_full", {15'd0, f_s_ready}, 16'd0);
    rand_state(); model(1'b0); push(0);
    f_m_ready = 1'b1;
    stalls = 0;
    send_state(0, 16, 15);
    chk("bp_resume_stalls", 16'(stalls), 16'd16);
    wait_drain(0);
    chk("bp_beats", 16'(f_beats - b0), 16'd48);

    // Framing: early s_last discards, missing s_last still commits.
    rand_state();
    send_state(0, 10, 9);
    chk("early_last_err", {15'd0, f_frame_err}, 16'd1);
    @(posedge clk); #1;
    chk("early_last_pulse", {15'd0, f_frame_err}, 16'd0);
    chk("early_last_no_out", {15'd0, f_m_valid}, 16'd0);
    rand_state(); model(1'b0); push(0);
    send_state(0, 16, 15);
    chk("after_err_clean", {15'd0, f_frame_err}, 16'd0);
    wait_drain(0);
    rand_state(); model(1'b0); push(0);
    send_state(0, 16, -1);
    chk("missing_last_err", {15'd0, f_frame_err}, 16'd1);
    chk("missing_last_valid", {15'd0, f_m_valid}, 16'd1);
    wait_drain(0);

    // Reset in the middle of draining a state.
    f_m_ready = 1'b0;
    rand_state(); model(1'b0); push(0);
    send_state(0, 16, 15);
    f_m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 f_m_ready = 1'b0;
    chk("mid_queue_left", 16'(q_f.size()), 16'd10);
    chk("mid_byte6", {7'd0, f_m_last, f_m_data}, {8'd0, ex[6]});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", {15'd0, f_m_valid}, 16'd0);
    chk("mid_rst_s_ready", {15'd0, f_s_ready}, 16'd1);
    q_f.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    f_m_ready = 1'b1;
    @(posedge clk); #1;
    rand_state(); model(1'b0); push(0);
    send_state(0, 16, 15);
    wait_drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
